nv_ram_fifo_ctl_4x128: RTL

NV_RAM_FIFO_CTL_4X128 -- requirements
Module: nv_ram_fifo_ctl_4x128

---
 rtl/nv_ram_fifo_ctl_4x128.sv | 116 +++++++++++
 1 files changed

// File: rtl/nv_ram_fifo_ctl_4x128.sv
// 4x128 in-order FIFO controller driving an external two-port RAM, with a 3-entry output skid buffer.
// Optional occupancy output fifo_occ is built when NV_RAM_FIFO_CTL_OCC_EN is defined.
module nv_ram_fifo_ctl_4x128 (
  input  logic         nvdla_core_clk,
  input  logic         nvdla_core_rstn,
  input  logic         wr_pvld,
  output logic         wr_prdy,
  input  logic [127:0] wr_pd,
  output logic         rd_pvld,
  input  logic         rd_prdy,
  output logic [127:0] rd_pd,
  output logic [1:0]   ram_wa,
  output logic         ram_we,
  output logic [127:0] ram_di,
  output logic [1:0]   ram_ra,
  output logic         ram_re,
  output logic         ram_ore,
  input  logic [127:0] ram_dout,
  input  logic [31:0]  pwrbus_ram_pd,
  output logic [31:0]  ram_pwrbus_ram_pd
`ifdef NV_RAM_FIFO_CTL_OCC_EN
  ,
  output logic [2:0]   fifo_occ
`endif
);

  localparam int DW   = 128;
  localparam int SKID = 3;

  logic [1:0]    wr_ptr, rd_ptr;
  logic [2:0]    ram_cnt;
  logic [2:1]    vld_pipe;
  logic          s1_vld, s2_vld;
  logic [1:0]    skid_cnt, skid_hd, skid_tl;
  logic [DW-1:0] skid_mem [SKID];
  logic [2:0]    inflight;
  logic          skid_nz, push_store, pop_store;

  function automatic logic [1:0] inc3(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  assign ram_pwrbus_ram_pd = pwrbus_ram_pd;

  assign s1_vld = vld_pipe[1];
  assign s2_vld = vld_pipe[2];

  // Credit: everything already issued plus buffered must fit in the skid.
  assign inflight = {2'b0, s1_vld} + {2'b0, s2_vld} + {1'b0, skid_cnt};

  assign wr_prdy = (ram_cnt < 3'd4);
  assign ram_we  = wr_pvld & wr_prdy;
  assign ram_wa  = wr_ptr;
  assign ram_di  = wr_pd;

  assign ram_re  = (ram_cnt != 3'd0) && (inflight < 3'd3);
  assign ram_ra  = rd_ptr;
  assign ram_ore = s1_vld;

  // Arriving RAM data bypasses the skid when it is empty so it is visible the same cycle.
  assign skid_nz    = (skid_cnt != 2'd0);
  assign rd_pvld    = skid_nz | s2_vld;
  assign rd_pd      = skid_nz ? skid_mem[skid_hd] : ram_dout;
  assign pop_store  = skid_nz & rd_prdy;
  assign push_store = s2_vld & ~(~skid_nz & rd_prdy);

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      wr_ptr  <= 2'd0;
      rd_ptr  <= 2'd0;
      ram_cnt <= 3'd0;
    end else begin
      if (ram_we) wr_ptr <= wr_ptr + 2'd1;
      if (ram_re) rd_ptr <= rd_ptr + 2'd1;
      case ({ram_we, ram_re})
        2'b10:   ram_cnt <= ram_cnt + 3'd1;
        2'b01:   ram_cnt <= ram_cnt - 3'd1;
        default: ram_cnt <= ram_cnt;
      endcase
    end
  end

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) vld_pipe <= 2'b00;
    else                  vld_pipe <= {vld_pipe[1], ram_re};
  end

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      skid_cnt <= 2'd0;
      skid_hd  <= 2'd0;
      skid_tl  <= 2'd0;
    end else begin
      if (push_store) skid_tl <= inc3(skid_tl);
      if (pop_store)  skid_hd <= inc3(skid_hd);
      case ({push_store, pop_store})
        2'b10:   skid_cnt <= skid_cnt + 2'd1;
        2'b01:   skid_cnt <= skid_cnt - 2'd1;
        default: skid_cnt <= skid_cnt;
      endcase
    end
  end

  always_ff @(posedge nvdla_core_clk) begin
    if (push_store) skid_mem[skid_tl] <= ram_dout;
  end

`ifdef NV_RAM_FIFO_CTL_OCC_EN
  // Bounded by 4 in RAM plus 3 in the read path, so 3 bits never wrap.
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) fifo_occ <= 3'd0;
    else                  fifo_occ <= ram_cnt + inflight;
  end
`endif

endmodule
